dmem_responder: RTL and testbench

Data-memory responder for the rv64 core's load/store port. It accepts one request at a time over a request/ready handshake and inserts a configurable number of wait states. It performs size-aware, byte-lane-masked writes and aligned-lane reads into a 64-bit-wide SRAM model. Every request gets exactly one response pulse. It sits on the core's data-memory interface and replaces the constant tie-offs used while no memory model exists.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/sram_1rw_sim.sv | 33 +++
 rtl/dmem_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the rv64 core's memory interfaces.
//   mem_size_t  - access size encoding on the data-memory port (B/H/W/D)
//   size_bytes  - number of bytes covered by a mem_size_t (1/2/4/8)
package riscv_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2,
      MEM_D = 2'd3
   } mem_size_t;

   function automatic logic [3:0] size_bytes(input mem_size_t sz);
      return 4'd1 << sz;
   endfunction

endpackage

// File: rtl/sram_1rw_sim.sv
// sram_1rw_sim: single-port DEPTH_WORDS x 64 memory model.
//   clk      - write clock (rising edge)
//   we_i     - write enable
//   be_i     - per-byte write enable, bit b covers wdata_i[8b+7:8b]
//   addr_i   - word index
//   wdata_i  - lane-aligned write data
//   rdata_o  - combinational read of the addressed word
// Contents are zero at time zero and are never cleared by reset.
module sram_1rw_sim #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [7:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [63:0]   wdata_i,
   output logic [63:0]   rdata_o
);

   logic [63:0] mem_q [DEPTH_WORDS] = '{default: '0};

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < 8; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the rv64 load/store port.
// One request at a time, LATENCY wait states, then a one-cycle response.
//   clk, rst        - clock and synchronous active-high reset
//   dmem_req_i      - request valid; accepted when dmem_ready_o is high
//   dmem_ready_o    - high only in IDLE
//   dmem_addr_i     - byte address
//   dmem_wen_i      - 1 = store, 0 = load
//   dmem_size_i     - access size (mem_size_t)
//   dmem_wdata_i    - right-aligned store data
//   dmem_rvalid_o   - one-cycle response pulse
//   dmem_rdata_o    - right-aligned, zero-extended load data (0 for stores/errors)
//   dmem_err_o      - misaligned or out-of-range access, valid with rvalid
//   tohost_o        - last doubleword stored to TOHOST_ADDR
//   tohost_valid_o  - sticky, set by the first tohost store
// Optional feature macro: DMEM_TOHOST_EN (adds the tohost register and ports).
module dmem_responder
   import riscv_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [63:0] TOHOST_ADDR = 64'h0000_1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_req_i,
   output logic        dmem_ready_o,
   input  logic [63:0] dmem_addr_i,
   input  logic        dmem_wen_i,
   input  mem_size_t   dmem_size_i,
   input  logic [63:0] dmem_wdata_i,
   output logic        dmem_rvalid_o,
   output logic [63:0] dmem_rdata_o,
   output logic        dmem_err_o
`ifdef DMEM_TOHOST_EN
  ,output logic [63:0] tohost_o,
   output logic        tohost_valid_o
`endif
);

   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   function automatic logic [7:0] be_mask(input mem_size_t sz, input logic [2:0] off);
      logic [7:0] m;
      case (sz)
         MEM_B:   m = 8'h01;
         MEM_H:   m = 8'h03;
         MEM_W:   m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << off;
   endfunction

   function automatic logic [63:0] lane_extract(input logic [63:0] d, input logic [2:0] off,
                                                input mem_size_t sz);
      logic [63:0] s;
      s = d >> {off, 3'b000};
      case (sz)
         MEM_B:   return {56'd0, s[7:0]};
         MEM_H:   return {48'd0, s[15:0]};
         MEM_W:   return {32'd0, s[31:0]};
         default: return s;
      endcase
   endfunction

   logic [1:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic        wen_q, wen_d;
   mem_size_t   size_q, size_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   // In IDLE the request being accepted is still on the inputs; afterwards the
   // latched copy is used. This lets LATENCY=0 sample the array in the accept cycle.
   logic [63:0] cur_addr;
   logic        cur_wen;
   mem_size_t   cur_size;
   logic [2:0]  cur_off;
   logic        acc_err;
   logic        th_hit;
   logic        th_near;
   logic [63:0] th_val;
   logic [63:0] sram_rdata;
   logic        store_commit;
   logic        sram_we;

   assign cur_addr = (state_q == S_IDLE) ? dmem_addr_i : addr_q;
   assign cur_wen  = (state_q == S_IDLE) ? dmem_wen_i  : wen_q;
   assign cur_size = (state_q == S_IDLE) ? dmem_size_i : size_q;
   assign cur_off  = cur_addr[2:0];

`ifdef DMEM_TOHOST_EN
   logic [63:0] tohost_q, tohost_d;
   logic        tohost_valid_q, tohost_valid_d;

   assign th_near = (cur_addr[63:3] == TOHOST_ADDR[63:3]);
   assign th_hit  = (cur_addr == TOHOST_ADDR) && (cur_size == MEM_D);
   assign th_val  = tohost_q;
`else
   assign th_near = 1'b0;
   assign th_hit  = 1'b0;
   assign th_val  = '0;
`endif

   // Inside the tohost doubleword only an exact D access is legal.
   assign acc_err = th_near ? !th_hit
                  : (((cur_off & 3'(size_bytes(cur_size) - 4'd1)) != 3'd0) ||
                     (cur_addr[63:3] >= 61'(DEPTH_WORDS)));

   // Stores commit on the edge leaving RESP; reset in RESP drops the write.
   assign store_commit = (state_q == S_RESP) && wen_q && !acc_err && !rst;
   assign sram_we      = store_commit && !th_hit;

   sram_1rw_sim #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_sram (
      .clk     (clk),
      .we_i    (sram_we),
      .be_i    (be_mask(size_q, addr_q[2:0])),
      .addr_i  (cur_addr[3 +: AW]),
      .wdata_i (wdata_q << {addr_q[2:0], 3'b000}),
      .rdata_o (sram_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wen_d   = wen_q;
      size_d  = size_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (dmem_req_i) begin
               addr_d  = dmem_addr_i;
               wdata_d = dmem_wdata_i;
               wen_d   = dmem_wen_i;
               size_d  = dmem_size_i;
               cnt_d   = CNT_INIT;
               if (LATENCY == 0) begin
                  state_d = S_RESP;
                  err_d   = acc_err;
                  rdata_d = (cur_wen || acc_err) ? 64'd0
                          : (th_hit ? th_val : lane_extract(sram_rdata, cur_off, cur_size));
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = S_RESP;
               err_d   = acc_err;
               rdata_d = (cur_wen || acc_err) ? 64'd0
                       : (th_hit ? th_val : lane_extract(sram_rdata, cur_off, cur_size));
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Request fields are only meaningful after an accept, so they carry no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
   end

`ifdef DMEM_TOHOST_EN
   always_comb begin
      tohost_d       = tohost_q;
      tohost_valid_d = tohost_valid_q;
      if (store_commit && th_hit) begin
         tohost_d       = wdata_q;
         tohost_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tohost_q       <= '0;
         tohost_valid_q <= 1'b0;
      end else begin
         tohost_q       <= tohost_d;
         tohost_valid_q <= tohost_valid_d;
      end
   end

   assign tohost_o       = tohost_q;
   assign tohost_valid_o = tohost_valid_q;
`endif

   assign dmem_ready_o  = (state_q == S_IDLE);
   assign dmem_rvalid_o = (state_q == S_RESP);
   assign dmem_rdata_o  = rdata_q;
   assign dmem_err_o    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responder instances (LATENCY=0 and LATENCY=2) driven
// by directed and random load/store traffic, checked against a byte-array
// reference model. Build with DMEM_TOHOST_EN to also cover the tohost register.
module tb_dmem_responder;
   import riscv_pkg::*;

   localparam int          DEPTH = 64;
   localparam logic [63:0] TOH   = 64'h0000_1000;
`ifdef DMEM_TOHOST_EN
   localparam bit TOH_EN = 1'b1;
`else
   localparam bit TOH_EN = 1'b0;
`endif
   localparam int LAT [2] = '{0, 2};

   logic        clk = 1'b0;
   logic        rst    [2];
   logic        req    [2];
   logic        wen    [2];
   mem_size_t   size   [2];
   logic [63:0] addr   [2];
   logic [63:0] wdata  [2];
   logic        ready  [2];
   logic        rvalid [2];
   logic [63:0] rdata  [2];
   logic        err    [2];
   logic [63:0] th_o   [2];
   logic        thv_o  [2];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .TOHOST_ADDR(TOH)) u_dut0 (
      .clk(clk), .rst(rst[0]), .dmem_req_i(req[0]), .dmem_ready_o(ready[0]),
      .dmem_addr_i(addr[0]), .dmem_wen_i(wen[0]), .dmem_size_i(size[0]),
      .dmem_wdata_i(wdata[0]), .dmem_rvalid_o(rvalid[0]), .dmem_rdata_o(rdata[0]),
      .dmem_err_o(err[0])
`ifdef DMEM_TOHOST_EN
     ,.tohost_o(th_o[0]), .tohost_valid_o(thv_o[0])
`endif
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .TOHOST_ADDR(TOH)) u_dut2 (
      .clk(clk), .rst(rst[1]), .dmem_req_i(req[1]), .dmem_ready_o(ready[1]),
      .dmem_addr_i(addr[1]), .dmem_wen_i(wen[1]), .dmem_size_i(size[1]),
      .dmem_wdata_i(wdata[1]), .dmem_rvalid_o(rvalid[1]), .dmem_rdata_o(rdata[1]),
      .dmem_err_o(err[1])
`ifdef DMEM_TOHOST_EN
     ,.tohost_o(th_o[1]), .tohost_valid_o(thv_o[1])
`endif
   );

   // Reference model: byte-addressed memory plus tohost register per instance.
   logic [7:0]  mm   [2][DEPTH*8];
   logic [63:0] th_m [2];
   logic        thv_m[2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_err(input logic [63:0] a, input logic [1:0] sz);
      int nb = 1 << sz;
      if (TOH_EN && (a[63:3] == TOH[63:3])) return !((a == TOH) && (sz == 2'd3));
      if ((a % nb) != 0) return 1'b1;
      if (a >= 64'(DEPTH * 8)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [63:0] m_load(input int i, input logic [63:0] a, input logic [1:0] sz);
      logic [63:0] r = '0;
      if (TOH_EN && (a == TOH)) return th_m[i];
      for (int k = 0; k < (1 << sz); k++) r[8*k +: 8] = mm[i][int'(a) + k];
      return r;
   endfunction

   task automatic xfer(input int i, input bit w, input logic [1:0] sz, input logic [63:0] a,
                       input logic [63:0] wd, output logic [63:0] rd, output logic er);
      int          n;
      bit          xe;
      logic [63:0] xr;
      @(negedge clk);
      req[i] = 1'b1; wen[i] = w; size[i] = mem_size_t'(sz); addr[i] = a; wdata[i] = wd;
      n = 0;
      while (!ready[i] && n < 20) begin @(negedge clk); n++; end
      if (!ready[i]) check("accept_timeout", 64'(ready[i]), 64'd1);
      @(posedge clk); #1 req[i] = 1'b0;
      @(negedge clk);
      n = 0;
      while (!rvalid[i] && n < 20) begin @(negedge clk); n++; end
      check($sformatf("lat%0d", i), 64'(n), 64'(LAT[i]));
      rd = rdata[i]; er = err[i];
      @(negedge clk);
      check("rvalid_pulse", 64'(rvalid[i]), 64'd0);
      check("ready_back", 64'(ready[i]), 64'd1);
      xe = m_err(a, sz);
      xr = (w || xe) ? 64'd0 : m_load(i, a, sz);
      check($sformatf("err a=%h sz=%0d w=%0d", a, sz, w), 64'(er), 64'(xe));
      check($sformatf("rdata a=%h sz=%0d w=%0d", a, sz, w), rd, xr);
      if (w && !xe) begin
         if (TOH_EN && (a == TOH)) begin
            th_m[i] = wd; thv_m[i] = 1'b1;
         end else begin
            for (int k = 0; k < (1 << sz); k++) mm[i][int'(a) + k] = wd[8*k +: 8];
         end
      end
   endtask

   logic [63:0] rd;
   logic        er;

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; req[i] = 1'b0; wen[i] = 1'b0; size[i] = MEM_B;
         addr[i] = '0; wdata[i] = '0; th_m[i] = '0; thv_m[i] = 1'b0;
         th_o[i] = '0; thv_o[i] = 1'b0;
         for (int b = 0; b < DEPTH*8; b++) mm[i][b] = 8'h00;
      end
      repeat (3) @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_ready",  64'(ready[i]),  64'd1);
         check("rst_rvalid", 64'(rvalid[i]), 64'd0);
         check("rst_rdata",  rdata[i],       64'd0);
         check("rst_err",    64'(err[i]),    64'd0);
`ifdef DMEM_TOHOST_EN
         check("rst_tohost",  th_o[i],        64'd0);
         check("rst_tohostv", 64'(thv_o[i]),  64'd0);
`endif
      end

      // Directed traffic on the LATENCY=2 instance.
      xfer(1, 1, 2'd3, 64'h40, 64'h1122_3344_5566_7788, rd, er);
      xfer(1, 0, 2'd3, 64'h40, 64'h0, rd, er);
      check("ld_d_40", rd, 64'h1122_3344_5566_7788);
      xfer(1, 1, 2'd0, 64'h43, 64'hFFFF_FFFF_FFFF_FFAB, rd, er);
      xfer(1, 0, 2'd3, 64'h40, 64'h0, rd, er);
      check("ld_d_after_sb", rd, 64'h1122_3344_AB66_7788);
      xfer(1, 0, 2'd1, 64'h42, 64'h0, rd, er);
      check("ld_h_42", rd, 64'h0000_0000_0000_AB66);
      xfer(1, 0, 2'd2, 64'h42, 64'h0, rd, er);
      check("misal_lw_err", 64'(er), 64'd1);
      xfer(1, 1, 2'd1, 64'h41, 64'hDEAD, rd, er);
      check("misal_sh_err", 64'(er), 64'd1);
      xfer(1, 0, 2'd3, 64'h40, 64'h0, rd, er);
      check("mem_unchanged", rd, 64'h1122_3344_AB66_7788);
      xfer(1, 0, 2'd3, 64'(DEPTH * 8), 64'h0, rd, er);
      check("oor_err", 64'(er), 64'd1);
      xfer(1, 1, 2'd3, 64'(DEPTH * 8), 64'h55, rd, er);

      // LATENCY=0: a held request is accepted on alternate cycles.
      @(negedge clk);
      req[0] = 1'b1; wen[0] = 1'b0; size[0] = MEM_D; addr[0] = 64'h0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("b2b_ready%0d", k),  64'(ready[0]),  64'(k % 2 == 0));
         check($sformatf("b2b_rvalid%0d", k), 64'(rvalid[0]), 64'(k % 2 == 1));
         if (k == 3) req[0] = 1'b0;
         @(negedge clk);
      end
      check("b2b_idle", 64'(ready[0]), 64'd1);

      // Reset during WAIT of a store drops it.
      @(negedge clk);
      req[1] = 1'b1; wen[1] = 1'b1; size[1] = MEM_D; addr[1] = 64'h80; wdata[1] = 64'hCAFE_F00D_1234_5678;
      @(posedge clk); #1 req[1] = 1'b0;
      @(negedge clk);
      check("wait_ready", 64'(ready[1]), 64'd0);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      check("rst_wait_ready", 64'(ready[1]), 64'd1);
      for (int k = 0; k < 4; k++) begin
         check("rst_wait_norv", 64'(rvalid[1]), 64'd0);
         @(negedge clk);
      end
      xfer(1, 0, 2'd3, 64'h80, 64'h0, rd, er);
      check("dropped_store", rd, 64'd0);

      // A request coinciding with reset is not accepted.
      @(negedge clk);
      rst[1] = 1'b1; req[1] = 1'b1; wen[1] = 1'b0; addr[1] = 64'h40;
      @(negedge clk);
      rst[1] = 1'b0; req[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("rst_req_norv", 64'(rvalid[1]), 64'd0);
         @(negedge clk);
      end

`ifdef DMEM_TOHOST_EN
      xfer(1, 1, 2'd3, TOH, 64'h1, rd, er);
      check("tohost_val", th_o[1], 64'h1);
      check("tohost_vld", 64'(thv_o[1]), 64'd1);
      xfer(1, 1, 2'd2, TOH, 64'h7, rd, er);
      check("tohost_sw_err", 64'(er), 64'd1);
      check("tohost_vld_sticky", 64'(thv_o[1]), 64'd1);
      check("tohost_unchanged", th_o[1], 64'h1);
      xfer(1, 0, 2'd3, TOH, 64'h0, rd, er);
      check("tohost_load", rd, 64'h1);
      xfer(1, 0, 2'd0, TOH + 64'd4, 64'h0, rd, er);
      check("tohost_near_err", 64'(er), 64'd1);
`endif

      // Random traffic on both instances.
      for (int it = 0; it < 240; it++) begin
         int          i;
         logic [1:0]  sz;
         logic [63:0] a;
         bit          w;
         i  = it % 2;
         sz = 2'($urandom_range(0, 3));
         w  = 1'($urandom_range(0, 1));
         a  = 64'($urandom_range(0, DEPTH * 8 - 1));
         if ($urandom_range(0, 9) < 8) a = a & ~64'((1 << sz) - 1);
         if ($urandom_range(0, 19) == 0) a = 64'(DEPTH * 8 + $urandom_range(0, 63));
         xfer(i, w, sz, a, {$urandom, $urandom}, rd, er);
      end

`ifdef DMEM_TOHOST_EN
      check("tohost_final", th_o[1], th_m[1]);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
